// File: rtl/crm_pkg.sv
// crm_pkg: shared sequencer state, counter sizing and default parameters
// for the clock/reset manager.
package crm_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN
    } crm_state_e;

    localparam int CRM_NUM_DOM     = 4;
    localparam int CRM_SYNC_STAGES = 2;
    localparam int CRM_RELEASE_GAP = 8;
    localparam int CRM_RST_PULSE   = 4;

    function automatic int cnt_width(input int num_dom, input int gap);
        return $clog2(num_dom * gap + 1);
    endfunction

endpackage

// File: rtl/crm_icg.sv
// crm_icg: latch-plus-AND clock gate; the latch is transparent while clk_in is low
// so enable changes only reach clk_out at the next rising edge.
module crm_icg (
    input  logic clk_in,
    input  logic en,
    output logic clk_out
);

    logic en_l;

    always_latch begin
        if (!clk_in) en_l = en;
    end

    assign clk_out = clk_in & en_l;

endmodule

// File: rtl/clock_reset_manager.sv
// clock_reset_manager: synchronised board reset, staggered domain release and per-domain
// clock gating; software reset pulses are built only when CRM_SW_RESET_EN is defined.
module clock_reset_manager
    import crm_pkg::*;
#(
    parameter int NUM_DOM     = CRM_NUM_DOM,
    parameter int SYNC_STAGES = CRM_SYNC_STAGES,
    parameter int RELEASE_GAP = CRM_RELEASE_GAP,
    parameter int RST_PULSE   = CRM_RST_PULSE
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_DOM-1:0] gate_req,
    input  logic [NUM_DOM-1:0] sw_rst_req,
    output logic [NUM_DOM-1:0] clk_out,
    output logic [NUM_DOM-1:0] rst_n_out,
    output logic [NUM_DOM-1:0] gate_ack,
    output logic               rst_done
);

    localparam int CW = cnt_width(NUM_DOM, RELEASE_GAP);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_rst_n;
    crm_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_nxt;
    logic [NUM_DOM-1:0]     rel_q, rel_d, rst_q, rst_d, en_q, en_d, ack_q, ack_d, pulse;
    logic                   done_q, done_d;

`ifdef CRM_SW_RESET_EN
    localparam int PW = $clog2(RST_PULSE + 1);
    logic [NUM_DOM-1:0][PW-1:0] pcnt_q, pcnt_d;

    // A request while a pulse is running reloads the counter, stretching the pulse.
    always_comb begin
        for (int k = 0; k < NUM_DOM; k++) begin
            pcnt_d[k] = (sw_rst_req[k] && state_q == S_RUN) ? PW'(RST_PULSE)
                                                             : pcnt_q[k] - PW'(pcnt_q[k] != '0);
            pulse[k]  = pcnt_d[k] != '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) pcnt_q <= '0;
        else           pcnt_q <= pcnt_d;
    end
`else
    localparam int unused_pulse = RST_PULSE;
    logic unused_sw_rst;
    assign unused_sw_rst = ^sw_rst_req;
    assign pulse         = '0;
`endif

    assign sync_rst_n = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
        cnt_nxt = cnt_q + 1'b1;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_HOLD: begin
                cnt_d   = '0;
                state_d = sync_rst_n ? S_RELEASE : S_HOLD;
            end
            S_RELEASE: begin
                cnt_d   = cnt_nxt;
                state_d = (cnt_nxt == CW'(NUM_DOM * RELEASE_GAP)) ? S_RUN : S_RELEASE;
            end
            default: ;
        endcase
        // The enable is held high both while in reset and on the edge that enters reset,
        // so a gated domain always sees a running clock during its reset.
        for (int k = 0; k < NUM_DOM; k++) begin
            rel_d[k] = rel_q[k] | (state_q == S_RELEASE && cnt_nxt == CW'((k + 1) * RELEASE_GAP));
            rst_d[k] = rel_d[k] & ~pulse[k];
            en_d[k]  = ~rst_q[k] | ~rst_d[k] | ~gate_req[k];
            ack_d[k] = ~en_q[k] & ~en_d[k];
        end
        done_d = state_d == S_RUN;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q  <= '0;
            state_q <= S_HOLD;
            cnt_q   <= '0;
            rel_q   <= '0;
            rst_q   <= '0;
            en_q    <= '1;
            ack_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            rst_q   <= rst_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_icg
        crm_icg u_icg (
            .clk_in (clk_in),
            .en     (en_q[g]),
            .clk_out(clk_out[g])
        );
    end

    assign rst_n_out = rst_q;
    assign gate_ack  = ack_q;
    assign rst_done  = done_q;

endmodule

// File: tb/tb_clock_reset_manager.sv
// tb_clock_reset_manager: directed scenario tests for clock_reset_manager at default
// parameters; software-reset expectations follow CRM_SW_RESET_EN.
module tb_clock_reset_manager;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int GAP  = 8;

    logic         clk_in     = 1'b0;
    logic         rst_n_in   = 1'b0;
    logic [N-1:0] gate_req   = '0;
    logic [N-1:0] sw_rst_req = '0;
    logic [N-1:0] clk_out, rst_n_out, gate_ack;
    logic         rst_done;

    int  checks = 0;
    int  errors = 0;
    bit  mon_on = 1'b0;
    time t_rise = 0;

    clock_reset_manager dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .gate_req  (gate_req),
        .sw_rst_req(sw_rst_req),
        .clk_out   (clk_out),
        .rst_n_out (rst_n_out),
        .gate_ack  (gate_ack),
        .rst_done  (rst_done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_out[0]) t_rise = $time;

    always @(negedge clk_out[0]) begin
        if (mon_on) begin
            checks++;
            if ($time - t_rise < 5) begin
                errors++;
                $display("FAIL glitch_clk0: high width %0t, required >= 5", $time - t_rise);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_sequence(input string tag);
        int rise[N];
        int done_at = -1;
        int clk_bad = 0;
        for (int k = 0; k < N; k++) rise[k] = -1;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (clk_out !== 4'hF) clk_bad++;
            for (int k = 0; k < N; k++)
                if (rise[k] < 0 && rst_n_out[k] === 1'b1) rise[k] = e;
            if (done_at < 0 && rst_done === 1'b1) done_at = e;
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (rise[k] !== SYNC + (k + 1) * GAP + 1) begin
                errors++;
                $display("FAIL %s_release%0d: edge %0d, required %0d", tag, k, rise[k],
                         SYNC + (k + 1) * GAP + 1);
            end
        end
        checks++;
        if (done_at !== SYNC + N * GAP + 1) begin
            errors++;
            $display("FAIL %s_done: edge %0d, required %0d", tag, done_at, SYNC + N * GAP + 1);
        end
        checks++;
        if (clk_bad !== 0) begin
            errors++;
            $display("FAIL %s_clk_running: %0d stopped samples, required 0", tag, clk_bad);
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        mon_on = 1'b1;
        checks++;
        if ({rst_n_out, gate_ack, rst_done} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: rst_n_out=%b gate_ack=%b rst_done=%b, required all 0",
                     rst_n_out, gate_ack, rst_done);
        end
        step();
        checks++;
        if (clk_out !== 4'hF) begin
            errors++;
            $display("FAIL reset_clk: clk_out=%b, required 1111", clk_out);
        end
    endtask

    task automatic test_power_on();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        check_sequence("power_on");
    endtask

    task automatic test_mid_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (20) step();
        checks++;
        if (rst_n_out !== 4'b0011) begin
            errors++;
            $display("FAIL mid_partial: rst_n_out=%b, required 0011", rst_n_out);
        end
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if (rst_n_out !== 4'b0000 || rst_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: rst_n_out=%b rst_done=%b, required 0000 0", rst_n_out, rst_done);
        end
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        check_sequence("mid_reset");
    endtask

    task automatic test_gating();
        logic [N-1:0] exp_clk[4] = '{4'hF, 4'b1011, 4'b1011, 4'b1011};
        logic [N-1:0] exp_ack[4] = '{4'h0, 4'b0100, 4'b0100, 4'b0100};
        @(negedge clk_in);
        gate_req = 4'b0100;
        for (int e = 0; e < 4; e++) begin
            step();
            checks++;
            if (clk_out !== exp_clk[e] || gate_ack !== exp_ack[e]) begin
                errors++;
                $display("FAIL gate_on_e%0d: clk_out=%b gate_ack=%b, required %b %b",
                         e + 1, clk_out, gate_ack, exp_clk[e], exp_ack[e]);
            end
        end
        @(negedge clk_in);
        gate_req = 4'b0000;
        step();
        checks++;
        if (clk_out !== 4'b1011 || gate_ack !== 4'b0000) begin
            errors++;
            $display("FAIL gate_off_e1: clk_out=%b gate_ack=%b, required 1011 0000", clk_out, gate_ack);
        end
        step();
        checks++;
        if (clk_out !== 4'hF || rst_n_out !== 4'hF) begin
            errors++;
            $display("FAIL gate_off_e2: clk_out=%b rst_n_out=%b, required 1111 1111", clk_out, rst_n_out);
        end
    endtask

    task automatic test_sw_reset();
        logic [N-1:0] exp_rst, exp_ack;
        logic         exp_r1;
        @(negedge clk_in);
        gate_req = 4'b0010;
        repeat (3) step();
        checks++;
        if (gate_ack !== 4'b0010) begin
            errors++;
            $display("FAIL sw_pre_ack: gate_ack=%b, required 0010", gate_ack);
        end
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk_in);
            sw_rst_req = (e == 1) ? 4'b0010 : 4'b0000;
            step();
`ifdef CRM_SW_RESET_EN
            exp_rst = (e <= 4) ? 4'b1101 : 4'hF;
            exp_ack = (e >= 7) ? 4'b0010 : 4'b0000;
            if (e >= 2 && e <= 4) begin
                checks++;
                if (clk_out[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL sw_clk_e%0d: clk_out[1]=%b, required 1", e, clk_out[1]);
                end
            end
`else
            exp_rst = 4'hF;
            exp_ack = 4'b0010;
`endif
            checks++;
            if (rst_n_out !== exp_rst || gate_ack !== exp_ack) begin
                errors++;
                $display("FAIL sw_pulse_e%0d: rst_n_out=%b gate_ack=%b, required %b %b",
                         e, rst_n_out, gate_ack, exp_rst, exp_ack);
            end
        end
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk_in);
            sw_rst_req = (e == 1 || e == 3) ? 4'b0010 : 4'b0000;
            step();
`ifdef CRM_SW_RESET_EN
            exp_r1 = (e >= 7);
`else
            exp_r1 = 1'b1;
`endif
            checks++;
            if (rst_n_out[1] !== exp_r1) begin
                errors++;
                $display("FAIL sw_restart_e%0d: rst_n_out[1]=%b, required %b", e, rst_n_out[1], exp_r1);
            end
        end
        @(negedge clk_in);
        gate_req = 4'b0000;
        repeat (3) step();
    endtask

    task automatic test_glitch();
        int high = 0;
        int ack_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            gate_req[0] = ~i[0];
            step();
            if (clk_out[0] === 1'b1) high++;
            if (gate_ack[0] !== 1'b0) ack_bad++;
        end
        @(negedge clk_in);
        gate_req = 4'b0000;
        checks++;
        if (high !== 50) begin
            errors++;
            $display("FAIL toggle_clk_pulses: %0d high samples, required 50", high);
        end
        checks++;
        if (ack_bad !== 0) begin
            errors++;
            $display("FAIL toggle_ack: %0d samples with ack, required 0", ack_bad);
        end
        repeat (2) step();
    endtask

    task automatic test_gate_during_reset();
        int ack_rise[N];
        int clk_low[N];
        @(negedge clk_in);
        rst_n_in = 1'b0;
        gate_req = 4'hF;
        for (int k = 0; k < N; k++) begin
            ack_rise[k] = -1;
            clk_low[k]  = -1;
        end
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (ack_rise[k] < 0 && gate_ack[k] === 1'b1) ack_rise[k] = e;
                if (clk_low[k] < 0 && clk_out[k] === 1'b0) clk_low[k] = e;
            end
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ack_rise[k] !== SYNC + (k + 1) * GAP + 3 || clk_low[k] !== SYNC + (k + 1) * GAP + 3) begin
                errors++;
                $display("FAIL held_gate%0d: ack edge %0d clk stop edge %0d, required %0d %0d",
                         k, ack_rise[k], clk_low[k], SYNC + (k + 1) * GAP + 3, SYNC + (k + 1) * GAP + 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_mid_reset();
        test_gating();
        test_sw_reset();
        test_glitch();
        test_gate_during_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_reset_manager.md
# clock_reset_manager

Multi-domain successor to the single-domain clock/reset unit: synchronises one asynchronous board reset, releases NUM_DOM domain resets in a fixed staggered order, and provides a per-domain clock gate with a request/acknowledge handshake for power-saving modes. It sits at the top of the pad-control design and feeds every functional domain's clock and reset.

## Interface
- NUM_DOM, 4: number of clock/reset domains (1..16).
- SYNC_STAGES, 2: reset synchroniser depth (>=2).
- RELEASE_GAP, 8: cycles between successive domain reset releases (>=1).
- RST_PULSE, 4: software-reset pulse length in cycles (>=1).
- clk_in  input  1  free-running source clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- gate_req  input  NUM_DOM  per-domain request to stop the clock (level).
- sw_rst_req  input  NUM_DOM  per-domain software reset request (one-cycle pulse).
- clk_out  output  NUM_DOM  gated domain clocks.
- rst_n_out  output  NUM_DOM  domain resets: asynchronous assert, synchronous deassert.
- gate_ack  output  NUM_DOM  high while the domain's clock is stopped.
- rst_done  output  1  high once all domains are released.

## Operation
- Synchroniser: SYNC_STAGES flops shift in 1 and clear asynchronously on rst_n_in low. sync_rst_n is the last stage.
- Sequencer FSM, state enum in the package:
  - S_HOLD: active while sync_rst_n is low.
  - S_HOLD -> S_RELEASE when sync_rst_n is high.
  - S_RELEASE: counter cnt increments each cycle. Domain k deasserts on the edge where cnt == (k+1)*RELEASE_GAP.
  - S_RELEASE -> S_RUN after domain NUM_DOM-1 is released.
- cnt width is $clog2(NUM_DOM*RELEASE_GAP+1). cnt saturates in S_RUN and never wraps.
- rst_n_in low at any time: the synchroniser, FSM and counters reset asynchronously. All rst_n_out fall immediately (no clock needed). FSM returns to S_HOLD.
- Clock gating: each domain has an enable register en[k] feeding the sub-module crm_icg (latch-based, latch transparent while clk_in is low, glitch-free).
  - While a domain is in reset or in a sw-reset pulse: en[k] is forced to 1 and gate_req[k] is ignored.
  - Otherwise, gate_req[k] high clears en[k] on the next edge. gate_ack[k] rises one edge after en[k] falls.
  - gate_req[k] low sets en[k] on the next edge. gate_ack[k] falls on the same edge.
- Reset values: rst_n_out = 0, en = all 1 (clk_out toggling), gate_ack = 0, rst_done = 0.

## Timing
- rst_n_in rise to sync_rst_n high: SYNC_STAGES edges.
- Domain k release: (k+1)*RELEASE_GAP + 1 edges after sync_rst_n rises. rst_done rises on the same edge as the last release.
- Gate latency: req to clock stopped, 1 edge plus the ICG half-cycle. Req to ack, 2 edges. Unreq to ack low, 1 edge.
- sw_rst_req[k] pulse in S_RUN: rst_n_out[k] low on the next edge, held for RST_PULSE cycles, then high. en[k] is forced to 1 and gate_ack[k] is 0 during the pulse.
- Boundary conditions:
  - sw_rst_req[k] and gate_req[k] in the same cycle: reset wins. After the pulse, the gate handshake restarts if gate_req[k] is still high.
  - sw_rst_req[k] outside S_RUN: ignored.
  - A new sw_rst_req[k] during a pulse: restarts the pulse counter.
  - gate_req toggled every cycle: en follows, with no glitch on clk_out.

## Configuration
- CRM_SW_RESET_EN:
  - Defined: the sw_rst_req port and per-domain pulse counters exist as described above.
  - Undefined: the sw_rst_req port still exists but is ignored, and no pulse counters are synthesised. After S_RUN, rst_n_out changes only on rst_n_in.

## Structure
- Package crm_pkg holds:
  - the sequencer enum (S_HOLD, S_RELEASE, S_RUN);
  - the counter-width function;
  - the default parameter constants.
- Sub-module crm_icg: latch plus AND clock gate (ports clk_in, en, clk_out), one instance per domain. It must map to a library ICG cell in synthesis.

## Test plan
- Power-on, NUM_DOM=4, RELEASE_GAP=8, SYNC_STAGES=2:
  - release rst_n_in -> rst_n_out[0..3] rise 11/19/27/35 edges later (9/17/25/33 edges after sync_rst_n rises);
  - rst_done rises with [3];
  - clk_out toggles throughout.
- Mid-sequence reset: rst_n_in low after domain 1 is released -> all rst_n_out low asynchronously within the same cycle; the full sequence repeats after release.
- Gating in S_RUN:
  - gate_req[2]=1 -> clk_out[2] stops after 1 edge, gate_ack[2]=1 after 2;
  - gate_req[2]=0 -> clock resumes, ack falls after 1 edge;
  - other domains are unaffected.
- Gate request during reset: gate_req=4'hF held from power-on -> each domain gates 1 edge after its own release; gate_ack is 0 before that.
- With CRM_SW_RESET_EN:
  - sw_rst_req[1] pulse with gate_req[1]=1 -> rst_n_out[1] low for 4 cycles with the clock running, then gate_ack[1] rises 2 edges after release.
  - Without the macro, the same stimulus leaves rst_n_out[1] high.
- Glitch check: gate_req[0] toggled every cycle for 100 cycles -> no clk_out[0] pulse shorter than half a period (assertion-monitored).
